// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver, 8N1, state on falling clock edge
// Optional stop-bit error reporting and break handling: define UART_RX_FRAME_ERR_EN
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_RX_Frame_Err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_d;
  logic          dv_d, active_d;
  logic [1:0]    sync_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

`ifdef UART_RX_FRAME_ERR_EN
  logic ferr_d;
`endif

  always_ff @(negedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= 8'h00;
      o_RX_Active <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      o_RX_Frame_Err <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], i_RX_Serial};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      o_RX_DV     <= dv_d;
      o_RX_Byte   <= byte_d;
      o_RX_Active <= active_d;
`ifdef UART_RX_FRAME_ERR_EN
      o_RX_Frame_Err <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = o_RX_Byte;
    dv_d     = 1'b0;
    active_d = o_RX_Active;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check at mid start bit so short low glitches never open a frame
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = DATA;
            active_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            dv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
`else
          dv_d   = 1'b1;
          byte_d = shift_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CLEANUP: begin
        cnt_d = '0;
`ifdef UART_RX_FRAME_ERR_EN
        // A held-low line (break) must return high before a new start is accepted
        if (rx_s) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

endmodule
